// File: rtl/seg7_pkg.sv
// Shared seven-segment constants for the stopwatch display path.
// Glyphs are active-low {g,f,e,d,c,b,a}.
package seg7_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  localparam logic [6:0] GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic logic [6:0] seg7_glyph(input logic [3:0] i_val);
    return GLYPH[i_val];
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex-digit to active-low seven-segment glyph decoder.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = seg7_glyph(i_digit);
  end

endmodule

// File: rtl/seg7_scan_display.sv
// Time-multiplexed common-anode display driver: per-frame digit snapshot,
// one blank cycle per slot against ghosting, optional leading-zero blanking.
module seg7_scan_display
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic                    clk_in,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic                    blank_lead,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_tick
);

  localparam int unsigned SW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [SW-1:0] SLOT_LAST = SW'(NUM_DIGITS - 1);
  localparam logic [PW-1:0] PCNT_LAST = PW'(REFRESH_DIV - 1);

  logic [PW-1:0]           r_pcnt;
  logic [SW-1:0]           r_slot;
  logic [4*NUM_DIGITS-1:0] r_snap;
  logic [NUM_DIGITS-1:0]   r_an;
  logic [6:0]              r_seg;
  logic                    r_dp;
  logic                    r_frame_tick;

  logic                    w_pcnt_wrap;
  logic                    w_frame_wrap;
  logic [3:0]              w_digit;
  logic [6:0]              w_glyph;
  logic [NUM_DIGITS-1:0]   w_an_lit;
  logic                    w_dp_bit;
  logic                    w_lead_zero_slot;
  logic [NUM_DIGITS-1:0]   w_lead_zero;
  logic                    w_zero_run;

  assign w_pcnt_wrap  = (r_pcnt == PCNT_LAST);
  assign w_frame_wrap = w_pcnt_wrap && (r_slot == SLOT_LAST);

  // Zero-run flag propagates from the most significant digit downward;
  // digit 0 is left out so it always stays visible.
  always_comb begin
    w_zero_run  = 1'b1;
    w_lead_zero = '0;
    for (int unsigned k = 0; k < NUM_DIGITS - 1; k++) begin
      w_zero_run = w_zero_run && (r_snap[4*(NUM_DIGITS-1-k) +: 4] == 4'h0);
      w_lead_zero[NUM_DIGITS-1-k] = w_zero_run;
    end
  end

  always_comb begin
    w_digit          = '0;
    w_an_lit         = '1;
    w_dp_bit         = 1'b0;
    w_lead_zero_slot = 1'b0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (r_slot == SW'(i)) begin
        w_digit          = r_snap[4*i +: 4];
        w_an_lit[i]      = 1'b0;
        w_dp_bit         = dp_mask[i];
        w_lead_zero_slot = w_lead_zero[i];
      end
    end
  end

  seg7_decode u_decode (
    .i_digit (w_digit),
    .o_seg   (w_glyph)
  );

  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_pcnt       <= '0;
      r_slot       <= '0;
      r_snap       <= '0;
      r_an         <= '1;
      r_seg        <= SEG_OFF;
      r_dp         <= 1'b1;
      r_frame_tick <= 1'b0;
    end else begin
      r_pcnt <= w_pcnt_wrap ? '0 : r_pcnt + 1'b1;
      if (w_pcnt_wrap) begin
        r_slot <= (r_slot == SLOT_LAST) ? '0 : r_slot + 1'b1;
      end
      if (w_frame_wrap) begin
        r_snap <= digits;
      end
      r_frame_tick <= w_frame_wrap;

      if ((r_pcnt == '0) || (blank_lead && w_lead_zero_slot)) begin
        r_an  <= '1;
        r_seg <= SEG_OFF;
        r_dp  <= 1'b1;
      end else begin
        r_an  <= w_an_lit;
        r_seg <= w_glyph;
        r_dp  <= ~w_dp_bit;
      end
    end
  end

  assign an         = r_an;
  assign seg        = r_seg;
  assign dp         = r_dp;
  assign frame_tick = r_frame_tick;

endmodule

// File: doc/seg7_scan_display.md
# seg7_scan_display

Time-multiplexed seven-segment display driver for the stopwatch: the reader side of the digit counters. It takes the packed BCD/hex digit values produced by the digit-counter chain and scans them onto a common-anode display. It snapshots all digits once per scan frame so the display never tears, blanks between digit slots to suppress ghosting, and optionally blanks leading zeros.

## Interface
Parameters:
- NUM_DIGITS, 4: number of display digits/anodes (2..8).
- REFRESH_DIV, 100000: clk_in cycles per digit slot (≥2).

Ports:
- clk_in  input  1  system clock; single clock domain.
- reset  input  1  synchronous, active-high reset.
- digits  input  4*NUM_DIGITS  packed digit values; digit i is digits[4i+3:4i], and digit 0 is the rightmost (least significant).
- dp_mask  input  NUM_DIGITS  1 lights the decimal point of that digit.
- blank_lead  input  1  1 enables leading-zero blanking.
- an  output  NUM_DIGITS  anode enables, active-low.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  output  1  decimal point, active-low.
- frame_tick  output  1  one-cycle pulse when a new snapshot is loaded.

## Operation
- Prescaler `pcnt` counts 0..REFRESH_DIV-1 and then wraps.
- Slot counter `slot` counts 0..NUM_DIGITS-1. It advances (mod NUM_DIGITS) on the edge where pcnt==REFRESH_DIV-1.
- Snapshot register `snap` (4*NUM_DIGITS bits):
  - Loads `digits` on the edge where pcnt==REFRESH_DIV-1 and slot==NUM_DIGITS-1, i.e. the frame wrap.
  - frame_tick=1 in the cycle after that edge only.
  - Changes to `digits` mid-frame have no visible effect until the next frame wrap.
- Decode of digit values:
  - 0–9 map to decimal glyphs.
  - 10–15 map to hex glyphs A, b, C, d, E, F.
  - Constants: 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10, A=7'h08, b=7'h03, C=7'h46, d=7'h21, E=7'h06, F=7'h0E.
- Leading-zero blanking, when blank_lead=1:
  - Digit i is blanked if snap digits NUM_DIGITS-1 down to i are all zero and i≠0.
  - Digit 0 is never blanked.
  - A blanked slot drives an all-ones, seg=7'h7F and dp=1.
- Inter-slot blanking: when pcnt==0, the outputs load an=all ones, seg=7'h7F and dp=1.
- Otherwise the outputs load:
  - an = ~(1<<slot);
  - seg = decode(snap digit slot);
  - dp = ~dp_mask[slot]. dp_mask is sampled live, not snapshotted.

## Timing
- an, seg, dp and frame_tick are all registered.
- Outputs reflect the pcnt/slot/snap values of the previous cycle (1-cycle latency).
- Per slot, with REFRESH_DIV=D:
  - 1 blank cycle, then D-1 lit cycles.
  - Frame period is NUM_DIGITS*D cycles.
- Reset values:
  - pcnt=0, slot=0, snap=0.
  - an=all ones, seg=7'h7F, dp=1, frame_tick=0.
- Reset overrides all other activity, including mid-frame. Reset asserted at edge k gives reset values after edge k. Scanning restarts at slot 0 with a blank cycle on the first edge after reset is released.
- First frame_tick occurs NUM_DIGITS*D edges after reset is released. Until then snap=0, so every slot shows "0", or digit 0 only when blank_lead=1.
- Simultaneous frame wrap and a `digits` change: the value present at the wrap edge is captured.

## Structure
- Package seg7_pkg holds:
  - the 16-entry glyph constant table;
  - SEG_OFF=7'h7F;
  - the decode function.
- One combinational sub-module, seg7_decode (4-bit in, 7-bit out), instantiated once on the muxed snap digit.
- Prescaler, slot counter, snapshot, blanking logic and output registers stay in seg7_scan_display.

## Test plan
Benches use NUM_DIGITS=4 and REFRESH_DIV=4 unless stated.
- Reset held 3 cycles → an=4'b1111, seg=7'h7F, dp=1, frame_tick=0. First frame_tick exactly 16 edges after release.
- digits=16'h1234, blank_lead=0, after first frame_tick → each slot shows 1 blank cycle, then 3 lit cycles of:
  - slot 0: an=4'b1110, seg=7'h19;
  - slot 1: an=4'b1101, seg=7'h30;
  - slot 2: an=4'b1011, seg=7'h24;
  - slot 3: an=4'b0111, seg=7'h79.
- blank_lead=1, digits=16'h0050 → slots 3 and 2 keep an=4'b1111; slot 1 shows seg=7'h12; slot 0 shows 7'h40. With digits=16'h0000, only slot 0 lights, with 7'h40.
- digits changed 16'h1234→16'h9999 mid-frame (slot 1) → glyphs stay 1234 until the cycle after the next frame_tick, then all slots show 7'h10.
- dp_mask=4'b0100 → dp=0 only in lit cycles of slot 2 (an=4'b1011); dp=1 in all blank cycles.
- Reset pulsed during slot 2, pcnt=2 → reset values on the next edge; after release the slot 0 sequence restarts and the next frame_tick comes 16 edges later.
